// File: rtl/acc_core_pkg.sv
// Shared definitions for the accumulator core: opcode values and control states.
package acc_core_pkg;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/acc_core_prog_mem.sv
// Program store: synchronous write, combinational read, contents survive reset.
module acc_core_prog_mem #(
  parameter int PC_W   = 4,
  parameter int WORD_W = PC_W + 2
) (
  input  logic              clock,
  input  logic              we,
  input  logic [PC_W-1:0]   waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [PC_W-1:0]   raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [2**PC_W];

  // write port
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/acc_core_param.sv
// Parametrised accumulator core: executes INC/JNO/HLT/LDI from an internal
// program memory, one instruction per clock while in RUN.
module acc_core_param
  import acc_core_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 4,
  parameter logic [DATA_W-1:0] INC_STEP = DATA_W'(1),
  parameter int              CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [PC_W+1:0]   prog_data,
  output logic [DATA_W-1:0] acc,
  output logic              status,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_e            state_r, state_s;
  logic [DATA_W-1:0] acc_r, acc_s;
  logic              status_r, status_s;
  logic [PC_W-1:0]   pc_r, pc_s, pc_inc_s;
  logic [CNT_W-1:0]  retired_r, retired_s, retired_inc_s;
  logic              busy_r, halted_r;
  logic [PC_W+1:0]   instr_s;
  logic [1:0]        opcode_s;
  logic [PC_W-1:0]   operand_s;
  logic [DATA_W:0]   sum_s;
  logic              mem_we_s;

  // writes are locked out while the program is executing
  assign mem_we_s = prog_we && (state_r != RUN);

  acc_core_prog_mem #(.PC_W(PC_W)) u_prog_mem (
    .clock (clock),
    .we    (mem_we_s),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_r),
    .rdata (instr_s)
  );

  assign opcode_s  = instr_s[PC_W+1:PC_W];
  assign operand_s = instr_s[PC_W-1:0];

  // next-state and datapath decode
  always_comb begin
    state_s       = state_r;
    acc_s         = acc_r;
    status_s      = status_r;
    pc_s          = pc_r;
    retired_s     = retired_r;
    sum_s         = {1'b0, acc_r} + {1'b0, INC_STEP};
    pc_inc_s      = pc_r + PC_W'(1);
    retired_inc_s = (retired_r == {CNT_W{1'b1}}) ? retired_r : retired_r + CNT_W'(1);
    case (state_r)
      RUN: begin
        retired_s = retired_inc_s;
        case (opcode_s)
          OP_INC: begin
            acc_s    = sum_s[DATA_W-1:0];
            status_s = status_r | sum_s[DATA_W];
            pc_s     = pc_inc_s;
          end
          OP_JNO: begin
            if (!status_r) begin
              pc_s = operand_s;
            end else begin
              pc_s = pc_inc_s;
            end
          end
          OP_HLT: begin
            state_s = HALTED;
          end
          OP_LDI: begin
            acc_s = DATA_W'(operand_s);
            pc_s  = pc_inc_s;
          end
          default: begin
            state_s = HALTED;
          end
        endcase
      end
      IDLE, HALTED: begin
        if (run) begin
          state_s   = RUN;
          acc_s     = '0;
          status_s  = 1'b0;
          pc_s      = '0;
          retired_s = '0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // architectural state and registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      acc_r     <= '0;
      status_r  <= 1'b0;
      pc_r      <= '0;
      retired_r <= '0;
      busy_r    <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      status_r  <= status_s;
      pc_r      <= pc_s;
      retired_r <= retired_s;
      busy_r    <= (state_s == RUN);
      halted_r  <= (state_s == HALTED);
    end
  end

  assign acc     = acc_r;
  assign status  = status_r;
  assign pc      = pc_r;
  assign busy    = busy_r;
  assign halted  = halted_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_acc_core_param.sv
// Self-checking bench: table of directed programs, hand sequences for the
// multi-cycle corners, and random programs against an ISA-level model.
module tb_acc_core_param;
  import acc_core_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instance A: DATA_W=8, PC_W=4, CNT_W=16
  logic       a_reset = 1'b0, a_run = 1'b0, a_we = 1'b0;
  logic [3:0] a_addr = 4'd0;
  logic [5:0] a_data = 6'd0;
  logic [7:0] a_acc;
  logic       a_status, a_busy, a_halted;
  logic [3:0] a_pc;
  logic [15:0] a_retired;

  // instance B: DATA_W=4, PC_W=4, CNT_W=4
  logic       b_reset = 1'b0, b_run = 1'b0, b_we = 1'b0;
  logic [3:0] b_addr = 4'd0;
  logic [5:0] b_data = 6'd0;
  logic [3:0] b_acc;
  logic       b_status, b_busy, b_halted;
  logic [3:0] b_pc;
  logic [3:0] b_retired;

  acc_core_param #(.DATA_W(8), .PC_W(4), .CNT_W(16)) dut_a (
    .clock(clock), .reset(a_reset), .run(a_run), .prog_we(a_we),
    .prog_addr(a_addr), .prog_data(a_data), .acc(a_acc), .status(a_status),
    .pc(a_pc), .busy(a_busy), .halted(a_halted), .retired(a_retired)
  );

  acc_core_param #(.DATA_W(4), .PC_W(4), .CNT_W(4)) dut_b (
    .clock(clock), .reset(b_reset), .run(b_run), .prog_we(b_we),
    .prog_addr(b_addr), .prog_data(b_data), .acc(b_acc), .status(b_status),
    .pc(b_pc), .busy(b_busy), .halted(b_halted), .retired(b_retired)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ins(input logic [1:0] op, input logic [3:0] opnd);
    return {op, opnd};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic rst, input logic rn, input logic we,
                         input logic [3:0] addr, input logic [5:0] data);
    a_reset = rst; a_run = rn; a_we = we; a_addr = addr; a_data = data;
    tick();
    a_reset = 1'b0; a_run = 1'b0; a_we = 1'b0;
  endtask

  task automatic drive_b(input logic rst, input logic rn, input logic we,
                         input logic [3:0] addr, input logic [5:0] data);
    b_reset = rst; b_run = rn; b_we = we; b_addr = addr; b_data = data;
    tick();
    b_reset = 1'b0; b_run = 1'b0; b_we = 1'b0;
  endtask

  task automatic load_a(input logic [15:0][5:0] prog);
    drive_a(1'b1, 1'b0, 1'b0, 4'd0, 6'd0);
    for (int i = 0; i < 16; i++) drive_a(1'b0, 1'b0, 1'b1, 4'(i), prog[i]);
  endtask

  task automatic wait_halt_a(input string name, input int bound);
    int n = 0;
    while (!a_halted && n < bound) begin
      drive_a(1'b0, 1'b0, 1'b0, 4'd0, 6'd0);
      n++;
    end
    check(name, int'(a_halted), 1);
  endtask

  task automatic check_final_a(input string tag, input int acc_e, input int st_e,
                               input int pc_e, input int ret_e);
    check({tag, "_acc"}, int'(a_acc), acc_e);
    check({tag, "_status"}, int'(a_status), st_e);
    check({tag, "_pc"}, int'(a_pc), pc_e);
    check({tag, "_retired"}, int'(a_retired), ret_e);
    check({tag, "_busy"}, int'(a_busy), 0);
  endtask

  // ISA-level reference model for instance A
  int m_mem [16];
  int m_acc, m_st, m_pc, m_ret, m_mode; // m_mode: 0 idle, 1 running, 2 halted

  task automatic model_step(input bit rst, input bit rn, input bit we, input int addr, input int data);
    int op, opnd;
    if (rst) begin
      m_mode = 0; m_acc = 0; m_st = 0; m_pc = 0; m_ret = 0;
      return;
    end
    if (m_mode == 1) begin
      op   = m_mem[m_pc] / 16;
      opnd = m_mem[m_pc] % 16;
      if (m_ret < 65535) m_ret = m_ret + 1;
      if (op == 0) begin
        m_acc = m_acc + 1;
        if (m_acc > 255) begin m_acc = m_acc - 256; m_st = 1; end
        m_pc = (m_pc + 1) % 16;
      end else if (op == 1) begin
        m_pc = (m_st == 0) ? opnd : (m_pc + 1) % 16;
      end else if (op == 2) begin
        m_mode = 2;
      end else begin
        m_acc = opnd;
        m_pc = (m_pc + 1) % 16;
      end
    end else begin
      if (we) m_mem[addr] = data;
      if (rn) begin
        m_mode = 1; m_acc = 0; m_st = 0; m_pc = 0; m_ret = 0;
      end
    end
  endtask

  task automatic cmp_model(input int cyc);
    string t;
    t = $sformatf("rnd_c%0d", cyc);
    check({t, "_acc"}, int'(a_acc), m_acc);
    check({t, "_status"}, int'(a_status), m_st);
    check({t, "_pc"}, int'(a_pc), m_pc);
    check({t, "_retired"}, int'(a_retired), m_ret);
    check({t, "_busy"}, int'(a_busy), int'(m_mode == 1));
    check({t, "_halted"}, int'(a_halted), int'(m_mode == 2));
  endtask

  typedef struct {
    logic [15:0][5:0] prog;
    int acc, st, pc, ret;
  } vec_t;

  vec_t tbl [4];
  logic [15:0][5:0] ovf;
  logic [5:0] hlt_w;

  initial begin
    hlt_w = ins(OP_HLT, 4'd0);

    // overflow loop
    tbl[0].prog = {16{hlt_w}};
    tbl[0].prog[0] = ins(OP_INC, 4'd0);
    tbl[0].prog[1] = ins(OP_JNO, 4'd0);
    tbl[0].acc = 0; tbl[0].st = 1; tbl[0].pc = 2; tbl[0].ret = 513;
    // LDI, INC, taken JNO to a distant HLT
    tbl[1].prog = {16{hlt_w}};
    tbl[1].prog[0] = ins(OP_LDI, 4'd15);
    tbl[1].prog[1] = ins(OP_INC, 4'd0);
    tbl[1].prog[2] = ins(OP_JNO, 4'd5);
    tbl[1].acc = 16; tbl[1].st = 0; tbl[1].pc = 5; tbl[1].ret = 4;
    // HLT at address 0
    tbl[2].prog = {16{hlt_w}};
    tbl[2].acc = 0; tbl[2].st = 0; tbl[2].pc = 0; tbl[2].ret = 1;
    // JNO skips a HLT, then LDI
    tbl[3].prog = {16{hlt_w}};
    tbl[3].prog[0] = ins(OP_JNO, 4'd2);
    tbl[3].prog[2] = ins(OP_LDI, 4'd9);
    tbl[3].acc = 9; tbl[3].st = 0; tbl[3].pc = 3; tbl[3].ret = 3;
    ovf = tbl[0].prog;

    // reset state
    drive_a(1'b1, 1'b0, 1'b0, 4'd0, 6'd0);
    drive_b(1'b1, 1'b0, 1'b0, 4'd0, 6'd0);
    check("rst_acc", int'(a_acc), 0);
    check("rst_status", int'(a_status), 0);
    check("rst_pc", int'(a_pc), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_halted", int'(a_halted), 0);
    check("rst_retired", int'(a_retired), 0);

    // table-driven programs
    for (int k = 0; k < 4; k++) begin
      load_a(tbl[k].prog);
      drive_a(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
      wait_halt_a($sformatf("tbl%0d_halt", k), 2000);
      check_final_a($sformatf("tbl%0d", k), tbl[k].acc, tbl[k].st, tbl[k].pc, tbl[k].ret);
    end

    // start latency and write ignored during RUN
    load_a(ovf);
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
    check("start_busy", int'(a_busy), 1);
    check("start_pc", int'(a_pc), 0);
    check("start_retired", int'(a_retired), 0);
    drive_a(1'b0, 1'b0, 1'b0, 4'd0, 6'd0);
    check("first_acc", int'(a_acc), 1);
    check("first_pc", int'(a_pc), 1);
    check("first_retired", int'(a_retired), 1);
    for (int i = 0; i < 8; i++) drive_a(1'b0, 1'b0, 1'b0, 4'd0, 6'd0);
    drive_a(1'b0, 1'b1, 1'b1, 4'd1, hlt_w);
    wait_halt_a("wrun_halt", 2000);
    check_final_a("wrun", 0, 1, 2, 513);

    // restart from HALTED clears state and reproduces the result
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
    check("restart_acc", int'(a_acc), 0);
    check("restart_status", int'(a_status), 0);
    check("restart_retired", int'(a_retired), 0);
    check("restart_busy", int'(a_busy), 1);
    check("restart_halted", int'(a_halted), 0);
    wait_halt_a("restart_halt", 2000);
    check_final_a("restart", 0, 1, 2, 513);

    // write while HALTED takes effect
    drive_a(1'b0, 1'b0, 1'b1, 4'd1, hlt_w);
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
    wait_halt_a("rewrite_halt", 100);
    check_final_a("rewrite", 1, 0, 1, 2);

    // reset mid-RUN (with run asserted) then a fresh run
    drive_a(1'b0, 1'b0, 1'b1, 4'd1, ins(OP_JNO, 4'd0));
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
    for (int i = 0; i < 20; i++) drive_a(1'b0, 1'b0, 1'b0, 4'd0, 6'd0);
    drive_a(1'b1, 1'b1, 1'b0, 4'd0, 6'd0);
    check("midrst_acc", int'(a_acc), 0);
    check("midrst_status", int'(a_status), 0);
    check("midrst_pc", int'(a_pc), 0);
    check("midrst_busy", int'(a_busy), 0);
    check("midrst_halted", int'(a_halted), 0);
    check("midrst_retired", int'(a_retired), 0);
    drive_a(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
    wait_halt_a("midrst_halt", 2000);
    check_final_a("midrst_rerun", 0, 1, 2, 513);

    // instance B: LDI then 4-bit overflow
    drive_b(1'b1, 1'b0, 1'b0, 4'd0, 6'd0);
    for (int i = 0; i < 16; i++) drive_b(1'b0, 1'b0, 1'b1, 4'(i), hlt_w);
    drive_b(1'b0, 1'b0, 1'b1, 4'd0, ins(OP_LDI, 4'd14));
    drive_b(1'b0, 1'b0, 1'b1, 4'd1, ins(OP_INC, 4'd0));
    drive_b(1'b0, 1'b0, 1'b1, 4'd2, ins(OP_INC, 4'd0));
    drive_b(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
    check("ldi_busy", int'(b_busy), 1);
    drive_b(1'b0, 1'b0, 1'b0, 4'd0, 6'd0);
    check("ldi_acc1", int'(b_acc), 14);
    drive_b(1'b0, 1'b0, 1'b0, 4'd0, 6'd0);
    check("ldi_acc2", int'(b_acc), 15);
    check("ldi_status2", int'(b_status), 0);
    drive_b(1'b0, 1'b0, 1'b0, 4'd0, 6'd0);
    check("ldi_acc3", int'(b_acc), 0);
    check("ldi_status3", int'(b_status), 1);
    drive_b(1'b0, 1'b0, 1'b0, 4'd0, 6'd0);
    check("ldi_halted", int'(b_halted), 1);
    check("ldi_busy4", int'(b_busy), 0);
    check("ldi_retired", int'(b_retired), 4);
    check("ldi_pc", int'(b_pc), 3);

    // instance B: pc wrap, counter saturation, run ignored while busy
    drive_b(1'b1, 1'b0, 1'b0, 4'd0, 6'd0);
    for (int i = 0; i < 16; i++) drive_b(1'b0, 1'b0, 1'b1, 4'(i), ins(OP_INC, 4'd0));
    drive_b(1'b0, 1'b1, 1'b0, 4'd0, 6'd0);
    for (int i = 1; i <= 40; i++) begin
      drive_b(1'b0, (i == 20) ? 1'b1 : 1'b0, 1'b0, 4'd0, 6'd0);
      check($sformatf("wrap%0d_pc", i), int'(b_pc), i % 16);
      check($sformatf("wrap%0d_acc", i), int'(b_acc), i % 16);
      check($sformatf("wrap%0d_status", i), int'(b_status), int'(i >= 16));
      check($sformatf("wrap%0d_retired", i), int'(b_retired), (i < 15) ? i : 15);
      check($sformatf("wrap%0d_busy", i), int'(b_busy), 1);
    end

    // random programs against the model
    for (int r = 0; r < 5; r++) begin
      drive_a(1'b1, 1'b0, 1'b0, 4'd0, 6'd0);
      model_step(1'b1, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 16; i++) begin
        int w;
        w = $urandom_range(0, 63);
        drive_a(1'b0, 1'b0, 1'b1, 4'(i), 6'(w));
        model_step(1'b0, 1'b0, 1'b1, i, w);
      end
      for (int c = 0; c < 80; c++) begin
        bit rn, we;
        int ad, dt;
        rn = (c == 0) || ($urandom_range(0, 9) == 0);
        we = ($urandom_range(0, 3) == 0);
        ad = $urandom_range(0, 15);
        dt = $urandom_range(0, 63);
        drive_a(1'b0, rn, we, 4'(ad), 6'(dt));
        model_step(1'b0, rn, we, ad, dt);
        cmp_model(r * 100 + c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_core_param.md
# acc_core_param

Parametrised accumulator core: the next-generation successor of the 2-bit INC/JNO/HLT test machine. It holds a DATA_W-bit accumulator, a sticky overflow status flag, a PC_W-bit program counter and an internal 2^PC_W-entry program memory loaded through a write port. It executes one instruction per clock while running, and adds an immediate-load opcode and an explicit run/halt handshake.

## Interface
- DATA_W, 8: accumulator width (≥2).
- PC_W, 4: program counter width; program depth is 2^PC_W.
- INC_STEP, 1: constant added by INC; DATA_W bits, must be nonzero.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  start pulse; sampled only in IDLE or HALTED.
- prog_we  in  1  program write enable; honoured only outside RUN.
- prog_addr  in  PC_W  program write address.
- prog_data  in  2+PC_W  instruction word {opcode[1:0], operand[PC_W-1:0]}.
- acc  out  DATA_W  accumulator.
- status  out  1  sticky overflow flag.
- pc  out  PC_W  current program counter.
- busy  out  1  high in RUN.
- halted  out  1  high in HALTED.
- retired  out  CNT_W  count of executed instructions, saturating.

## Operation
- Opcodes:
  - 00 INC: acc <= acc + INC_STEP mod 2^DATA_W. Carry-out sets status; status is never cleared by INC. pc <= pc+1.
  - 01 JNO: if status==0, pc <= operand; else pc <= pc+1.
  - 10 HLT: go to HALTED; pc holds the HLT address.
  - 11 LDI: acc <= zero-extended operand; status unchanged; pc <= pc+1.
- States:
  - IDLE: entered after reset. Accepts program writes. On run, go to RUN with pc=0.
  - RUN: one instruction executed per clock edge. Instruction is read combinationally from memory[pc].
  - HALTED: accepts program writes. On run, go to RUN with pc=0, acc=0, status=0 and retired=0.
- pc increments wrap from 2^PC_W-1 to 0.
- retired increments on every executed instruction, including HLT; it saturates at 2^CNT_W-1.
- prog_we during RUN is ignored; memory is unchanged.
- In IDLE, a write and run in the same cycle are both performed.
- Reset values: state IDLE, acc=0, status=0, pc=0, busy=0, halted=0, retired=0. Program memory is not cleared by reset.
- Reset asserted mid-RUN: next edge returns the core to the reset values above, with memory retained. Reset overrides run.

## Timing
- All outputs are registered.
- Memory write is synchronous: data is visible at the next edge.
- run high at edge N in IDLE/HALTED: busy=1 after N. The instruction at address 0 executes at edge N+1.
- Instruction latency is 1 cycle: effects appear in outputs right after the executing edge.
- HLT executed at edge M: after M, busy=0, halted=1, and retired includes the HLT.
- An overflowing INC at edge M: status=1 after M. A JNO at edge M+1 falls through.
- run while busy is ignored.

## Structure
- Shared package acc_core_pkg holds:
  - opcode constants OP_INC=2'b00, OP_JNO=2'b01, OP_HLT=2'b10, OP_LDI=2'b11;
  - state encoding IDLE/RUN/HALTED.
- One natural sub-module, acc_core_prog_mem: 2^PC_W × (2+PC_W) memory, synchronous write, asynchronous read, no reset.
- The accumulator adder is inline: DATA_W+1-bit sum, MSB is the carry.

## Test plan
- Overflow loop (DATA_W=8, INC_STEP=1): load {0:INC, 1:JNO 0, 2:HLT}, pulse run. Expect halted with acc=0x00, status=1, pc=2, retired=513.
- LDI then overflow: load {0:LDI 14, 1:INC, 2:INC, 3:HLT} with DATA_W=4, INC_STEP=1. Expect acc=0 and status=1 after edge 3, and halted with retired=4.
- PC wrap (PC_W=2): load {0:LDI 1, 1:INC, 2:INC, 3:JNO 0}. pc sequence is 0,1,2,3,0,…; busy stays 1; retired increments every cycle.
- Write during RUN: issue prog_we to address 1 with HLT while running the overflow loop. Expect no change in behaviour. After halt, rewrite address 1 with HLT and run; expect halt at pc=1, acc=1, retired=2.
- Reset mid-RUN: assert reset one cycle during the overflow loop. Expect acc=0, status=0, pc=0, busy=0, retired=0 next cycle. A fresh run re-executes the retained program and yields the same final values as the first scenario.
- Restart from HALTED: pulse run after the first scenario. Expect acc, status and retired cleared at start, and the identical final result.
